// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with byte lanes, burst tracking and wait states
// Scratch RAM behind the AHB decoder; errors are two-cycle and never touch memory.
module ahb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int CHECK_SEQ   = 1
) (
  input  logic                  clk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [1:0]            htrans,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_READY, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                state, state_nxt;
  logic [2:0]            wcnt;
  logic [ADDR_WIDTH-1:0] pred;
  logic                  dp_valid, dp_write;
  logic [IDXW-1:0]       dp_idx;
  logic [NB-1:0]         dp_be;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  addr_ok, accept, acc_err, acc_ok;
  logic [ADDR_WIDTH-1:0] word_addr, incr, sum, wrap_mask, next_addr;
  logic                  wrap;
  logic [IDXW-1:0]       acc_idx, rd_idx;
  logic [NB-1:0]         acc_be;
  logic                  wr_commit, rd_load;
  logic [DATA_WIDTH-1:0] rd_word;

  // Address phases are only sampled while this slave drives hreadyout high.
  assign addr_ok   = (state == S_READY) || (state == S_ERR2);
  assign accept    = hsel && hready && htrans[1] && addr_ok;
  assign word_addr = haddr >> OFFW;
  assign acc_idx   = word_addr[IDXW-1:0];
  assign incr      = ADDR_WIDTH'(1) << hsize;
  assign sum       = haddr + incr;

  assign acc_err = (word_addr >= ADDR_WIDTH'(DEPTH))
                 || (hsize > 3'(OFFW))
                 || (|(haddr & (incr - ADDR_WIDTH'(1))))
                 || ((CHECK_SEQ != 0) && (htrans == 2'b11) && (haddr != pred));
  assign acc_ok  = accept && !acc_err;

  always_comb begin
    wrap      = 1'b1;
    wrap_mask = '0;
    case (hburst)
      3'b010:  wrap_mask = (incr << 2) - ADDR_WIDTH'(1);
      3'b100:  wrap_mask = (incr << 3) - ADDR_WIDTH'(1);
      3'b110:  wrap_mask = (incr << 4) - ADDR_WIDTH'(1);
      default: wrap = 1'b0;
    endcase
    next_addr = wrap ? ((haddr & ~wrap_mask) | (sum & wrap_mask)) : sum;
  end

  always_comb begin
    int off, nbytes;
    off    = int'(haddr[OFFW-1:0]);
    nbytes = 1 << int'(hsize);
    acc_be = '0;
    for (int b = 0; b < NB; b++) acc_be[b] = (b >= off) && (b < off + nbytes);
  end

  // Zero-wait reads sample memory at acceptance, so they need the bypass from a
  // write completing on the same edge; waited reads sample after the last WAIT cycle.
  assign wr_commit = dp_valid && dp_write && (state == S_READY);
  assign rd_load   = (WAIT_STATES == 0) ? (acc_ok && !hwrite)
                                        : ((state == S_WAIT) && (wcnt == 3'd0) && !dp_write);
  assign rd_idx    = (WAIT_STATES == 0) ? acc_idx : dp_idx;

  always_comb begin
    rd_word = mem[rd_idx];
    for (int b = 0; b < NB; b++)
      if (wr_commit && (dp_idx == rd_idx) && dp_be[b]) rd_word[8*b +: 8] = hwdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) state <= S_READY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      S_READY, S_ERR2: begin
        hresp = (state == S_ERR2);
        if (accept && acc_err)                  state_nxt = S_ERR1;
        else if (accept && (WAIT_STATES > 0))   state_nxt = S_WAIT;
        else                                    state_nxt = S_READY;
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (wcnt == 3'd0) state_nxt = S_READY;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = S_ERR2;
      end
      default: state_nxt = S_READY;
    endcase
  end

  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      wcnt     <= 3'd0;
      pred     <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= '0;
      hrdata   <= '0;
    end else begin
      if ((state == S_WAIT) && (wcnt != 3'd0)) wcnt <= wcnt - 3'd1;
      if (accept) pred <= next_addr;
      if (addr_ok) dp_valid <= acc_ok;
      if (acc_ok) begin
        dp_write <= hwrite;
        dp_idx   <= acc_idx;
        dp_be    <= acc_be;
        wcnt     <= WS_LOAD;
      end
      if (rd_load) hrdata <= rd_word;
    end
  end

  // Storage is deliberately left unreset so committed words survive a bus reset.
  always_ff @(posedge clk) begin
    if (wr_commit)
      for (int b = 0; b < NB; b++)
        if (dp_be[b]) mem[dp_idx][8*b +: 8] <= hwdata[8*b +: 8];
  end

endmodule
